id_stage_pipelined: RTL

ID_STAGE_PIPELINED -- requirements
Module: id_stage_pipelined

---
 rtl/id_stage_pipelined_pkg.sv | 119 +++++++++++
 rtl/id_stage_pipelined_if.sv | 38 +++
 rtl/id_stage_pipelined_regfile_bypass.sv | 33 +++
 rtl/id_stage_pipelined.sv | 99 +++++++++
 4 files changed

// File: rtl/id_stage_pipelined_pkg.sv
`default_nettype none
//==== id_stage_pipelined_pkg -- encodings, control struct, decode/condition helpers ====
//==== rev 1.0 ====
package id_stage_pipelined_pkg;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10,
    MODE_NOP = 2'b11
  } mode_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_ADD = 4'b0100,
    OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_TST = 4'b1000, OP_CMP = 4'b1010,
    OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_MVN = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010, CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100, CMD_SBC = 4'b0101, CMD_AND = 4'b0110, CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000, CMD_MVN = 4'b1001
  } cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef struct packed {
    logic       wb;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       s;
    logic [3:0] cmd;
    logic       use_src1;
    logic       use_src2;
    logic       is_str;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [1:0] mode, input logic imm,
                                   input logic [3:0] opcode, input logic s_bit);
    ctrl_t c;
    c = '0;
    case (mode)
      MODE_DP: begin
        c.s        = s_bit;
        c.use_src1 = 1'b1;
        c.use_src2 = ~imm;
        c.wb       = 1'b1;
        case (opcode)
          OP_MOV:  begin c.cmd = CMD_MOV; c.use_src1 = 1'b0; end
          OP_MVN:  begin c.cmd = CMD_MVN; c.use_src1 = 1'b0; end
          OP_ADD:  c.cmd = CMD_ADD;
          OP_ADC:  c.cmd = CMD_ADC;
          OP_SUB:  c.cmd = CMD_SUB;
          OP_SBC:  c.cmd = CMD_SBC;
          OP_AND:  c.cmd = CMD_AND;
          OP_ORR:  c.cmd = CMD_ORR;
          OP_EOR:  c.cmd = CMD_EOR;
          OP_CMP:  begin c.cmd = CMD_SUB; c.wb = 1'b0; end
          OP_TST:  begin c.cmd = CMD_AND; c.wb = 1'b0; end
          default: begin c.cmd = CMD_NOP; c.wb = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        c.cmd      = CMD_ADD;
        c.use_src1 = 1'b1;
        if (s_bit) begin
          c.mem_rd = 1'b1;
          c.wb     = 1'b1;
        end else begin
          c.mem_wr   = 1'b1;
          c.is_str   = 1'b1;
          c.use_src2 = 1'b1;
        end
      end
      MODE_BR: c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] st);
    logic n, z, c, v;
    n = st[ST_N];
    z = st[ST_Z];
    c = st[ST_C];
    v = st[ST_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_pipelined_if.sv
`default_nettype none
//==== id_stage_pipelined_if -- decode-side inputs, hazard info and ID/EX outputs ====
//==== rev 1.0 ====
interface id_stage_pipelined_if #(parameter int DATA_W = 32);
  logic              instr_valid;
  logic [31:0]       instruction;
  logic [3:0]        status;
  logic              wb_en;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [3:0]        hz_ex_dest;
  logic              hz_ex_wb;
  logic              hz_ex_memrd;
  logic [3:0]        hz_mem_dest;
  logic              hz_mem_wb;
  logic              stall;
  logic              ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_s, ex_imm;
  logic [3:0]        ex_cmd, ex_dest, ex_src1, ex_src2;
  logic [DATA_W-1:0] ex_val_rn, ex_val_rm;
  logic [11:0]       ex_shift_op;
  logic [23:0]       ex_simm24;

  modport master (
    output instr_valid, instruction, status, wb_en, wb_dest, wb_data, flush,
           hz_ex_dest, hz_ex_wb, hz_ex_memrd, hz_mem_dest, hz_mem_wb,
    input  stall, ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_s, ex_imm,
           ex_cmd, ex_dest, ex_src1, ex_src2, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24
  );

  modport slave (
    input  instr_valid, instruction, status, wb_en, wb_dest, wb_data, flush,
           hz_ex_dest, hz_ex_wb, hz_ex_memrd, hz_mem_dest, hz_mem_wb,
    output stall, ex_valid, ex_wb_en, ex_mem_rd, ex_mem_wr, ex_branch, ex_s, ex_imm,
           ex_cmd, ex_dest, ex_src1, ex_src2, ex_val_rn, ex_val_rm, ex_shift_op, ex_simm24
  );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipelined_regfile_bypass.sv
`default_nettype none
//==== regfile_bypass -- NREG x DATA_W register file, two async reads, write-through ====
//==== rev 1.0 ====
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [AW-1:0]     i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic [AW-1:0]     i_raddr1,
  input  wire logic [AW-1:0]     i_raddr2,
  output logic      [DATA_W-1:0] o_rdata1,
  output logic      [DATA_W-1:0] o_rdata2
);
  logic [DATA_W-1:0] r_mem [NREG];

  // Reset has priority, so a write landing in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];
  assign o_rdata2 = (i_we && (i_waddr == i_raddr2)) ? i_wdata : r_mem[i_raddr2];
endmodule
`default_nettype wire

// File: rtl/id_stage_pipelined.sv
`default_nettype none
//==== id_stage_pipelined -- ARM-style decode, hazard stall and ID/EX register ====
//==== rev 1.0 ====
module id_stage_pipelined
  import id_stage_pipelined_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int FWD_EN = 0
) (
  input wire logic             clk,
  input wire logic             rst,
  id_stage_pipelined_if.slave  bus
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  ctrl_t             w_ctrl;
  logic              w_pass;
  logic [3:0]        w_src1, w_src2;
  logic [DATA_W-1:0] w_rn, w_rm;
  logic              w_hit_ex, w_hit_mem, w_hazard, w_stall, w_bubble;

  logic              r_valid, r_wb, r_mrd, r_mwr, r_br, r_s, r_imm;
  logic [3:0]        r_cmd, r_dest, r_src1, r_src2;
  logic [DATA_W-1:0] r_rn, r_rm;
  logic [11:0]       r_shop;
  logic [23:0]       r_simm;

  always_comb begin
    w_ctrl = decode(bus.instruction[27:26], bus.instruction[25],
                    bus.instruction[24:21], bus.instruction[20]);
    w_pass = cond_pass(bus.instruction[31:28], bus.status);
    w_src1 = bus.instruction[19:16];
    w_src2 = w_ctrl.is_str ? bus.instruction[15:12] : bus.instruction[3:0];
  end

  regfile_bypass #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_we     (bus.wb_en),
    .i_waddr  (bus.wb_dest[AW-1:0]),
    .i_wdata  (bus.wb_data),
    .i_raddr1 (w_src1[AW-1:0]),
    .i_raddr2 (w_src2[AW-1:0]),
    .o_rdata1 (w_rn),
    .o_rdata2 (w_rm)
  );

  // With forwarding, only a load in EX cannot be bypassed in time.
  assign w_hit_ex  = bus.hz_ex_wb & ((w_ctrl.use_src1 & (w_src1 == bus.hz_ex_dest)) |
                                     (w_ctrl.use_src2 & (w_src2 == bus.hz_ex_dest)));
  assign w_hit_mem = bus.hz_mem_wb & ((w_ctrl.use_src1 & (w_src1 == bus.hz_mem_dest)) |
                                      (w_ctrl.use_src2 & (w_src2 == bus.hz_mem_dest)));
  assign w_hazard  = (FWD_EN != 0) ? (bus.hz_ex_memrd & w_hit_ex) : (w_hit_ex | w_hit_mem);
  assign w_stall   = ~rst & bus.instr_valid & ~bus.flush & w_hazard;
  assign w_bubble  = bus.flush | w_stall | ~bus.instr_valid;
  assign bus.stall = w_stall;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      {r_valid, r_wb, r_mrd, r_mwr, r_br, r_s, r_imm} <= '0;
      {r_cmd, r_dest, r_src1, r_src2}                 <= '0;
      {r_rn, r_rm, r_shop, r_simm}                    <= '0;
    end else begin
      r_valid <= 1'b1;
      r_wb    <= w_pass & w_ctrl.wb;
      r_mrd   <= w_pass & w_ctrl.mem_rd;
      r_mwr   <= w_pass & w_ctrl.mem_wr;
      r_br    <= w_pass & w_ctrl.branch;
      r_s     <= w_pass & w_ctrl.s;
      r_cmd   <= w_pass ? w_ctrl.cmd : 4'b0000;
      r_imm   <= bus.instruction[25];
      r_dest  <= bus.instruction[15:12];
      r_src1  <= w_src1;
      r_src2  <= w_src2;
      r_rn    <= w_rn;
      r_rm    <= w_rm;
      r_shop  <= bus.instruction[11:0];
      r_simm  <= bus.instruction[23:0];
    end
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_wb_en    = r_wb;
  assign bus.ex_mem_rd   = r_mrd;
  assign bus.ex_mem_wr   = r_mwr;
  assign bus.ex_branch   = r_br;
  assign bus.ex_s        = r_s;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_cmd      = r_cmd;
  assign bus.ex_dest     = r_dest;
  assign bus.ex_src1     = r_src1;
  assign bus.ex_src2     = r_src2;
  assign bus.ex_val_rn   = r_rn;
  assign bus.ex_val_rm   = r_rm;
  assign bus.ex_shift_op = r_shop;
  assign bus.ex_simm24   = r_simm;
endmodule
`default_nettype wire
